// File: rtl/sal_axi_tg_pkg.sv
// Shared types and constants for the SAL AXI3 traffic generator.
// AXI encodings match the SAL DDR controller's AXI ports.
package sal_axi_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_DONE
  } tg_state_e;

  localparam int unsigned TG_BEATS  = 2;
  localparam int unsigned TG_STRIDE = 32;
  localparam int unsigned TG_DATA_W = 128;
  localparam int unsigned TG_STRB_W = TG_DATA_W / 8;

  localparam logic [3:0] TG_AXLEN       = 4'(TG_BEATS - 1);
  localparam logic [2:0] AXI_SIZE_128   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic inc);
    return (inc && value != 16'hFFFF) ? value + 16'd1 : value;
  endfunction

endpackage

// File: rtl/sal_axi_tg_pattern.sv
// Data pattern for one 128b beat: word = (addr | beat<<4) ^ SEED, replicated 4x.
// Pure combinational; used for both write data and read-back expectation.
module sal_axi_tg_pattern
  import sal_axi_tg_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter logic [31:0] SEED   = 32'hA5A5_5A5A
) (
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic                 beat_i,
  output logic [TG_DATA_W-1:0] data_o
);

  logic [31:0] addr32;
  logic [31:0] word;

  if (ADDR_W >= 32) begin : g_trunc
    assign addr32 = addr_i[31:0];
  end else begin : g_ext
    assign addr32 = {{(32 - ADDR_W){1'b0}}, addr_i};
  end

  assign word   = (addr32 | {27'd0, beat_i, 4'd0}) ^ SEED;
  assign data_o = {4{word}};

endmodule

// File: rtl/sal_axi_traffic_gen.sv
// AXI3 self-checking traffic generator: writes NUM_TXN 2-beat INCR bursts,
// reads them back, compares against the pattern and reports done/pass/err_cnt.
module sal_axi_traffic_gen
  import sal_axi_tg_pkg::*;
#(
  parameter int unsigned       ID_W      = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ID_W-1:0]   TXN_ID    = '0,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       NUM_TXN   = 16,
  parameter logic [31:0]       SEED      = 32'hA5A5_5A5A,
  parameter int unsigned       TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_cnt,
  output logic [ID_W-1:0]      awid,
  output logic [ADDR_W-1:0]    awaddr,
  output logic [3:0]           awlen,
  output logic [2:0]           awsize,
  output logic [1:0]           awburst,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [ID_W-1:0]      wid,
  output logic [TG_DATA_W-1:0] wdata,
  output logic [TG_STRB_W-1:0] wstrb,
  output logic                 wlast,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [ID_W-1:0]      bid,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready,
  output logic [ID_W-1:0]      arid,
  output logic [ADDR_W-1:0]    araddr,
  output logic [3:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [ID_W-1:0]      rid,
  input  logic [TG_DATA_W-1:0] rdata,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  input  logic                 rvalid,
  output logic                 rready
);

  localparam int unsigned       WDOG_W    = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
  localparam logic [15:0]       LAST_IDX  = 16'(NUM_TXN - 1);
  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(TG_STRIDE);

  tg_state_e             state_q;
  logic [15:0]           idx_q;
  logic [15:0]           err_cnt_q;
  logic [15:0]           err_cnt_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [WDOG_W-1:0]     wdog_q;
  logic                  busy_q, done_q, pass_q;
  logic                  awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
  logic                  aw_done_q, w_done_q, r_beat_q;
  logic [TG_DATA_W-1:0]  wdata_q;

  logic                  aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic                  progress, timeout, last_txn;
  logic                  b_err, r_err, err_inc;
  logic [ADDR_W-1:0]     next_addr;
  logic [ADDR_W-1:0]     wr_pat_addr;
  logic                  wr_pat_beat;
  logic [TG_DATA_W-1:0]  wr_pat_data;
  logic [TG_DATA_W-1:0]  rd_exp_data;

  assign aw_fire  = awvalid_q & awready;
  assign w_fire   = wvalid_q & wready;
  assign b_fire   = bready_q & bvalid;
  assign ar_fire  = arvalid_q & arready;
  assign r_fire   = rready_q & rvalid;
  assign progress = aw_fire | w_fire | b_fire | ar_fire | r_fire;
  assign timeout  = busy_q & ~progress & (wdog_q == WDOG_LAST);
  assign last_txn = (idx_q == LAST_IDX);
  assign next_addr = addr_q + STRIDE;

  assign b_err = b_fire & ((bid != TXN_ID) | (bresp != AXI_RESP_OKAY));
  assign r_err = r_fire & ((rdata != rd_exp_data) | (rresp != AXI_RESP_OKAY) |
                           (rid != TXN_ID) | (rlast != r_beat_q));
  assign err_inc   = b_err | r_err | timeout;
  assign err_cnt_d = sat_inc16(err_cnt_q, err_inc);

  // Write pattern source: beat1 of the current burst while in WR_REQ,
  // otherwise beat0 of whichever burst is about to be launched.
  assign wr_pat_beat = (state_q == ST_WR_REQ);
  assign wr_pat_addr = (state_q == ST_WR_REQ)  ? addr_q    :
                       (state_q == ST_WR_RESP) ? next_addr : BASE_ADDR;

  sal_axi_tg_pattern #(.ADDR_W(ADDR_W), .SEED(SEED)) u_wr_pat (
    .addr_i (wr_pat_addr),
    .beat_i (wr_pat_beat),
    .data_o (wr_pat_data)
  );

  sal_axi_tg_pattern #(.ADDR_W(ADDR_W), .SEED(SEED)) u_rd_pat (
    .addr_i (addr_q),
    .beat_i (r_beat_q),
    .data_o (rd_exp_data)
  );

  // NOTE: all state here is non-blocking; ports below are direct register
  // copies, so no ready input can reach a valid output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      err_cnt_q <= '0;
      addr_q    <= '0;
      wdog_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      r_beat_q  <= 1'b0;
      wdata_q   <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      if (!busy_q || progress) wdog_q <= '0;
      else                     wdog_q <= wdog_q + WDOG_W'(1);

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_WR_REQ;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= '0;
            idx_q     <= '0;
            addr_q    <= BASE_ADDR;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            wlast_q   <= 1'b0;
            wdata_q   <= wr_pat_data;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end

        ST_WR_REQ: begin
          if (aw_fire) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_fire) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              w_done_q <= 1'b1;
            end else begin
              wlast_q <= 1'b1;
              wdata_q <= wr_pat_data;
            end
          end
          if ((aw_done_q | aw_fire) && (w_done_q | (w_fire & wlast_q))) begin
            state_q  <= ST_WR_RESP;
            bready_q <= 1'b1;
          end
        end

        ST_WR_RESP: begin
          if (b_fire) begin
            bready_q <= 1'b0;
            if (last_txn) begin
              idx_q     <= '0;
              addr_q    <= BASE_ADDR;
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_REQ;
            end else begin
              idx_q     <= idx_q + 16'd1;
              addr_q    <= next_addr;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              wlast_q   <= 1'b0;
              wdata_q   <= wr_pat_data;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= ST_WR_REQ;
            end
          end
        end

        ST_RD_REQ: begin
          if (ar_fire) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            r_beat_q  <= 1'b0;
            state_q   <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (r_fire) begin
            if (r_beat_q) begin
              rready_q <= 1'b0;
              if (last_txn) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                // pass must see an error flagged on this final beat too
                pass_q  <= (err_cnt_d == 16'd0);
                state_q <= ST_DONE;
              end else begin
                idx_q     <= idx_q + 16'd1;
                addr_q    <= next_addr;
                arvalid_q <= 1'b1;
                state_q   <= ST_RD_REQ;
              end
            end else begin
              r_beat_q <= 1'b1;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase

      if (timeout) begin
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        wlast_q   <= 1'b0;
        bready_q  <= 1'b0;
        arvalid_q <= 1'b0;
        rready_q  <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
        pass_q    <= 1'b0;
        state_q   <= ST_DONE;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_cnt_q;

  assign awid    = TXN_ID;
  assign awaddr  = addr_q;
  assign awlen   = TG_AXLEN;
  assign awsize  = AXI_SIZE_128;
  assign awburst = AXI_BURST_INCR;
  assign awvalid = awvalid_q;

  assign wid     = TXN_ID;
  assign wdata   = wdata_q;
  assign wstrb   = '1;
  assign wlast   = wlast_q;
  assign wvalid  = wvalid_q;

  assign bready  = bready_q;

  assign arid    = TXN_ID;
  assign araddr  = addr_q;
  assign arlen   = TG_AXLEN;
  assign arsize  = AXI_SIZE_128;
  assign arburst = AXI_BURST_INCR;
  assign arvalid = arvalid_q;

  assign rready  = rready_q;

endmodule
